// File: rtl/mem_port_sequencer.sv
// Serialises 32-bit word loads/stores from two requesters (A, B) into
// big-endian byte accesses on the external memory's single 8-bit data port.
module mem_port_sequencer #(
  parameter int ADDR_W = 8,
  parameter bit RR     = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [31:0]       a_wdata,
  output logic              a_done,
  output logic [31:0]       a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wdata,
  output logic              b_done,
  output logic [31:0]       b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_w,
  output logic              mem_wen,
  input  logic [7:0]        mem_r
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            state_q;
  logic [2:0]        cnt_q;
  logic [ADDR_W-3:0] base_q;
  logic [31:0]       wdata_q;
  logic [23:0]       shadow_q;
  logic              gnt_b_q;
  logic              last_b_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_w_q;
  logic              mem_wen_q;
  logic              a_done_q;
  logic              b_done_q;
  logic [31:0]       a_rdata_q;
  logic [31:0]       b_rdata_q;

  logic              gnt_b_d;
  logic              sel_we_d;
  logic [ADDR_W-3:0] sel_base_d;
  logic [31:0]       sel_wdata_d;
  logic [1:0]        nxt_off_d;
  logic [7:0]        nxt_lane_d;
  logic [31:0]       rd_word_d;
  logic              addr_lsb_unused;

  // Accesses are always word-aligned, so the byte-offset address bits are dropped.
  assign addr_lsb_unused = ^{a_addr[1:0], b_addr[1:0]};

  always_comb begin
    gnt_b_d = b_req;
    if (a_req && b_req) begin
      gnt_b_d = RR ? !last_b_q : 1'b0;
    end
    sel_we_d    = gnt_b_d ? b_we : a_we;
    sel_base_d  = gnt_b_d ? b_addr[ADDR_W-1:2] : a_addr[ADDR_W-1:2];
    sel_wdata_d = gnt_b_d ? b_wdata : a_wdata;
    nxt_off_d   = cnt_q[1:0] + 2'd1;
    case (nxt_off_d)
      2'd0:    nxt_lane_d = wdata_q[31:24];
      2'd1:    nxt_lane_d = wdata_q[23:16];
      2'd2:    nxt_lane_d = wdata_q[15:8];
      default: nxt_lane_d = wdata_q[7:0];
    endcase
    rd_word_d = {shadow_q, mem_r};
  end

  // mem_r lags mem_addr by one edge, so RD runs one cycle longer than WR
  // and the final byte goes straight from mem_r into rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      base_q     <= '0;
      wdata_q    <= '0;
      shadow_q   <= '0;
      gnt_b_q    <= 1'b0;
      last_b_q   <= 1'b1;
      mem_addr_q <= '0;
      mem_w_q    <= '0;
      mem_wen_q  <= 1'b0;
      a_done_q   <= 1'b0;
      b_done_q   <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          mem_wen_q <= 1'b0;
          if (a_req || b_req) begin
            gnt_b_q    <= gnt_b_d;
            last_b_q   <= gnt_b_d;
            base_q     <= sel_base_d;
            wdata_q    <= sel_wdata_d;
            cnt_q      <= 3'd0;
            mem_addr_q <= {sel_base_d, 2'b00};
            if (sel_we_d) begin
              state_q   <= WR;
              mem_wen_q <= 1'b1;
              mem_w_q   <= sel_wdata_d[31:24];
            end else begin
              state_q <= RD;
            end
          end
        end
        RD: begin
          case (cnt_q)
            3'd1:    shadow_q[23:16] <= mem_r;
            3'd2:    shadow_q[15:8]  <= mem_r;
            3'd3:    shadow_q[7:0]   <= mem_r;
            default: ;
          endcase
          if (cnt_q == 3'd4) begin
            state_q <= DONE;
            if (gnt_b_q) begin
              b_done_q  <= 1'b1;
              b_rdata_q <= rd_word_d;
            end else begin
              a_done_q  <= 1'b1;
              a_rdata_q <= rd_word_d;
            end
          end else begin
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q != 3'd3) begin
              mem_addr_q <= {base_q, nxt_off_d};
            end
          end
        end
        WR: begin
          if (cnt_q == 3'd3) begin
            state_q   <= DONE;
            mem_wen_q <= 1'b0;
            if (gnt_b_q) begin
              b_done_q <= 1'b1;
            end else begin
              a_done_q <= 1'b1;
            end
          end else begin
            cnt_q      <= cnt_q + 3'd1;
            mem_addr_q <= {base_q, nxt_off_d};
            mem_w_q    <= nxt_lane_d;
          end
        end
        DONE: begin
          a_done_q <= 1'b0;
          b_done_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_done   = a_done_q;
  assign b_done   = b_done_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign mem_addr = mem_addr_q;
  assign mem_w    = mem_w_q;
  assign mem_wen  = mem_wen_q;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Bench for mem_port_sequencer: a round-robin and a fixed-priority instance,
// each on its own byte memory, checked against a word-level reference memory.
module tb_mem_port_sequencer;

  logic        clk;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [7:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;

  logic        a_done, b_done, mem_wen;
  logic [31:0] a_rdata, b_rdata;
  logic [7:0]  mem_addr, mem_w, mem_r;

  logic        a_done0, b_done0, mem_wen0;
  logic [31:0] a_rdata0, b_rdata0;
  logic [7:0]  mem_addr0, mem_w0, mem_r0;

  logic [7:0]  mem1 [256];
  logic [7:0]  mem0 [256];
  logic [7:0]  init_mem [256];
  logic [7:0]  ref_mem [256];
  logic        mem_load;

  int          total;
  int          bad;
  bit          model_last;
  logic [31:0] exp_a_rdata, exp_b_rdata, saved_b0, mid_w;
  int          waited;
  bit          got, win_b, r_who, r_we, r_scr;

  mem_port_sequencer #(.ADDR_W(8), .RR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_done(b_done), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_w(mem_w), .mem_wen(mem_wen), .mem_r(mem_r)
  );

  mem_port_sequencer #(.ADDR_W(8), .RR(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_done(a_done0), .a_rdata(a_rdata0),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_done(b_done0), .b_rdata(b_rdata0),
    .mem_addr(mem_addr0), .mem_w(mem_w0), .mem_wen(mem_wen0), .mem_r(mem_r0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External memories: synchronous byte write, read data registered one edge late.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) begin
        mem1[8'(i)] <= init_mem[8'(i)];
        mem0[8'(i)] <= init_mem[8'(i)];
      end
    end else begin
      if (mem_wen) mem1[mem_addr] <= mem_w;
      if (mem_wen0) mem0[mem_addr0] <= mem_w0;
    end
    mem_r  <= mem1[mem_addr];
    mem_r0 <= mem0[mem_addr0];
  end

  function automatic logic [31:0] refWord(input logic [7:0] addr);
    logic [7:0] b;
    b = {addr[7:2], 2'b00};
    return {ref_mem[b], ref_mem[b + 8'd1], ref_mem[b + 8'd2], ref_mem[b + 8'd3]};
  endfunction

  function automatic logic [31:0] memWord(input logic [7:0] addr);
    logic [7:0] b;
    b = {addr[7:2], 2'b00};
    return {mem1[b], mem1[b + 8'd1], mem1[b + 8'd2], mem1[b + 8'd3]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one uncontended access from cycle 0 (an IDLE cycle) through its done pulse.
  task automatic applyStimulus(input bit who, input bit we, input logic [7:0] addr,
                               input logic [31:0] wdata, input bit scramble);
    int         lat;
    int         done_cyc;
    logic [31:0] exp_word;
    logic [1:0] off;
    logic [7:0] b;
    lat      = we ? 5 : 6;
    done_cyc = 0;
    exp_word = refWord(addr);
    if (who) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
    end
    for (int c = 1; c <= 9 && done_cyc == 0; c++) begin
      @(posedge clk); #1;
      if (scramble && c == 2) begin
        if (who) begin
          b_addr = 8'h20; b_we = ~we; b_wdata = $urandom;
        end else begin
          a_addr = 8'h20; a_we = ~we; a_wdata = $urandom;
        end
      end
      @(negedge clk);
      checkOutput("other_done", 32'(who ? a_done : b_done), 32'd0);
      if (c <= 4) begin
        off = 2'(c - 1);
        checkOutput("mem_addr", 32'(mem_addr), 32'({addr[7:2], off}));
        checkOutput("mem_wen", 32'(mem_wen), 32'(we));
        if (we) checkOutput("mem_w", 32'(mem_w), 32'(wdata[8*(4-c) +: 8]));
      end
      if ((who ? b_done : a_done) === 1'b1) done_cyc = c;
    end
    checkOutput("latency", 32'(done_cyc), 32'(lat));
    checkOutput("done_wen", 32'(mem_wen), 32'd0);
    if (we) begin
      b = {addr[7:2], 2'b00};
      ref_mem[b]         = wdata[31:24];
      ref_mem[b + 8'd1]  = wdata[23:16];
      ref_mem[b + 8'd2]  = wdata[15:8];
      ref_mem[b + 8'd3]  = wdata[7:0];
      checkOutput("mem_word", memWord(addr), wdata);
    end else if (who) begin
      exp_b_rdata = exp_word;
    end else begin
      exp_a_rdata = exp_word;
    end
    checkOutput("a_rdata", a_rdata, exp_a_rdata);
    checkOutput("b_rdata", b_rdata, exp_b_rdata);
    model_last = who;
    @(posedge clk); #1;
    if (who) b_req = 1'b0; else a_req = 1'b0;
    @(negedge clk);
    checkOutput("done_pulse", 32'({a_done, b_done}), 32'd0);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; mem_load = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = 8'h00; a_wdata = 32'h0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 8'h00; b_wdata = 32'h0;
    for (int i = 0; i < 256; i++) init_mem[8'(i)] = 8'($urandom);
    init_mem[8'h0C] = 8'hDE; init_mem[8'h0D] = 8'hAD;
    init_mem[8'h0E] = 8'hBE; init_mem[8'h0F] = 8'hEF;
    for (int i = 0; i < 256; i++) ref_mem[8'(i)] = init_mem[8'(i)];
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_load = 1'b0;
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_mem_w", 32'(mem_w), 32'd0);
    checkOutput("rst_mem_wen", 32'(mem_wen), 32'd0);
    checkOutput("rst_done", 32'({a_done, b_done}), 32'd0);
    checkOutput("rst_a_rdata", a_rdata, 32'd0);
    checkOutput("rst_b_rdata", b_rdata, 32'd0);
    rst_n = 1'b1;
    model_last = 1'b1; exp_a_rdata = 32'd0; exp_b_rdata = 32'd0;
    @(negedge clk);

    applyStimulus(1'b0, 1'b0, 8'h0E, 32'h0, 1'b0);
    checkOutput("load_deadbeef", a_rdata, 32'hDEADBEEF);

    applyStimulus(1'b1, 1'b1, 8'h10, 32'h12345678, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h10, 32'h0, 1'b0);
    checkOutput("b_load_back", b_rdata, 32'h12345678);

    applyStimulus(1'b0, 1'b0, 8'h0C, 32'h0, 1'b1);
    checkOutput("hold_rdata", a_rdata, 32'hDEADBEEF);

    // Both requesters held high: round-robin alternates, fixed priority always picks A.
    saved_b0 = exp_b_rdata;
    a_we = 1'b0; b_we = 1'b0; a_addr = 8'h40; b_addr = 8'h50;
    a_req = 1'b1; b_req = 1'b1;
    for (int n = 0; n < 4; n++) begin
      got = 1'b0; waited = 0;
      for (int w = 1; w <= 10 && !got; w++) begin
        @(negedge clk);
        if (a_done === 1'b1 || b_done === 1'b1) begin
          got = 1'b1; waited = w;
        end
      end
      win_b = !model_last;
      checkOutput("cont_latency", 32'(waited), (n == 0) ? 32'd6 : 32'd7);
      checkOutput("cont_a_done", 32'(a_done), 32'(!win_b));
      checkOutput("cont_b_done", 32'(b_done), 32'(win_b));
      checkOutput("fixed_a_done", 32'(a_done0), 32'd1);
      checkOutput("fixed_b_done", 32'(b_done0), 32'd0);
      if (win_b) exp_b_rdata = refWord(8'h50); else exp_a_rdata = refWord(8'h40);
      checkOutput("cont_a_rdata", a_rdata, exp_a_rdata);
      checkOutput("cont_b_rdata", b_rdata, exp_b_rdata);
      checkOutput("fixed_a_rdata", a_rdata0, refWord(8'h40));
      checkOutput("fixed_b_rdata", b_rdata0, saved_b0);
      model_last = win_b;
    end
    @(posedge clk); #1;
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    checkOutput("cont_end_done", 32'({a_done, b_done, a_done0, b_done0}), 32'd0);

    for (int k = 0; k < 12; k++) begin
      r_who = 1'($urandom_range(0, 1));
      r_we  = 1'($urandom_range(0, 1));
      r_scr = 1'($urandom_range(0, 1));
      applyStimulus(r_who, r_we, 8'($urandom_range(0, 255)), $urandom, r_scr);
    end

    // Abort a store after its first two bytes have been written.
    mid_w = $urandom;
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h30; a_wdata = mid_w;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("mid_wen", 32'(mem_wen), 32'd1);
    rst_n = 1'b0; a_req = 1'b0;
    #1;
    checkOutput("rst_wen_async", 32'(mem_wen), 32'd0);
    checkOutput("rst_abort_done", 32'({a_done, b_done}), 32'd0);
    ref_mem[8'h30] = mid_w[31:24];
    ref_mem[8'h31] = mid_w[23:16];
    model_last = 1'b1; exp_a_rdata = 32'd0; exp_b_rdata = 32'd0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("rst_hold_done", 32'({a_done, b_done}), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("partial_word", memWord(8'h30), refWord(8'h30));
    checkOutput("rst_a_rdata2", a_rdata, 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h30, 32'h0, 1'b0);

    repeat (20) begin
      @(negedge clk);
      checkOutput("idle_wen", 32'(mem_wen), 32'd0);
      checkOutput("idle_done", 32'({a_done, b_done}), 32'd0);
      checkOutput("idle_a_rdata", a_rdata, exp_a_rdata);
      checkOutput("idle_b_rdata", b_rdata, exp_b_rdata);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
